// File: rtl/oflow_score_board_pkg.sv
// Shared types and default constants for the multi-candidate object score board.
package oflow_score_board_pkg;

    typedef enum logic [1:0] {
        PTR_NONE = 2'b00,
        PTR_ADV  = 2'b01,
        PTR_SET  = 2'b10
    } ptr_cmd_e;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } sb_state_e;

    localparam int DEF_ROWS    = 32;
    localparam int DEF_K       = 2;
    localparam int DEF_SCORE_W = 16;
    localparam int DEF_ID_W    = 12;

    localparam logic [63:0] INVALID_SCORE = '1;

endpackage

// File: rtl/oflow_score_board_multi_if.sv
// Write handshake between the registration stage and the score board.
interface oflow_score_board_multi_if #(
    parameter int ROW_W   = 5,
    parameter int K       = 2,
    parameter int SCORE_W = 16,
    parameter int ID_W    = 12
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [ROW_W-1:0]     wr_row;
    logic [K*SCORE_W-1:0] wr_scores;
    logic [K*ID_W-1:0]    wr_ids;
    logic                 wr_done;

    modport master (output wr_valid, wr_row, wr_scores, wr_ids, input wr_ready, wr_done);
    modport slave  (input wr_valid, wr_row, wr_scores, wr_ids, output wr_ready, wr_done);
endinterface

// File: rtl/oflow_sb_row.sv
// One score-board row: K ranked (score,id) slots, active pointer, written flag and active mux.
module oflow_sb_row
    import oflow_score_board_pkg::*;
#(
    parameter int K       = DEF_K,
    parameter int SCORE_W = DEF_SCORE_W,
    parameter int ID_W    = DEF_ID_W,
    parameter int PTR_W   = $clog2(K + 1)
) (
    input  logic                 clk,
    input  logic                 reset_N,
    input  logic                 clr,
    input  logic                 we,
    input  logic [K*SCORE_W-1:0] wr_scores,
    input  logic [K*ID_W-1:0]    wr_ids,
    input  logic [1:0]           ptr_cmd,
    input  logic [PTR_W-1:0]     ptr_val,
    output logic [SCORE_W-1:0]   act_score,
    output logic [ID_W-1:0]      act_id,
    output logic                 act_valid,
    output logic                 exhausted,
    output logic                 written
);
    localparam logic [PTR_W-1:0] PTR_K = PTR_W'(K);

    logic [K*SCORE_W-1:0] scores_q;
    logic [K*ID_W-1:0]    ids_q;
    logic [PTR_W-1:0]     ptr_q;
    logic                 vld_q;

    // A write in the same cycle as a pointer command wins and restarts at the best candidate.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            scores_q <= '0;
            ids_q    <= '0;
            ptr_q    <= '0;
            vld_q    <= 1'b0;
        end else if (clr) begin
            scores_q <= '0;
            ids_q    <= '0;
            ptr_q    <= '0;
            vld_q    <= 1'b0;
        end else if (we) begin
            scores_q <= wr_scores;
            ids_q    <= wr_ids;
            ptr_q    <= '0;
            vld_q    <= 1'b1;
        end else begin
            case (ptr_cmd)
                PTR_ADV: if (ptr_q != PTR_K) ptr_q <= ptr_q + PTR_W'(1);
                PTR_SET: ptr_q <= (ptr_val > PTR_K) ? PTR_K : ptr_val;
                default: ;
            endcase
        end
    end

    always_comb begin
        act_valid = vld_q && (ptr_q < PTR_K);
        act_score = INVALID_SCORE[SCORE_W-1:0];
        act_id    = '0;
        for (int j = 0; j < K; j++) begin
            if (act_valid && (ptr_q == PTR_W'(j))) begin
                act_score = scores_q[j*SCORE_W +: SCORE_W];
                act_id    = ids_q[j*ID_W +: ID_W];
            end
        end
    end

    assign exhausted = (ptr_q == PTR_K);
    assign written   = vld_q;

endmodule

// File: rtl/oflow_score_board_multi.sv
// Score board of ROWS rows x K ranked candidates: write FSM, filled-row counter, row decode, read muxes.
module oflow_score_board_multi
    import oflow_score_board_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int K       = DEF_K,
    parameter int SCORE_W = DEF_SCORE_W,
    parameter int ID_W    = DEF_ID_W,
    parameter int ROW_W   = $clog2(ROWS),
    parameter int PTR_W   = $clog2(K + 1)
) (
    input  logic                     clk,
    input  logic                     reset_N,
    input  logic                     new_frame,
    oflow_score_board_multi_if.slave wr,
    input  logic [1:0]               ptr_cmd,
    input  logic [ROW_W-1:0]         ptr_row,
    input  logic [PTR_W-1:0]         ptr_val,
    input  logic [ROW_W-1:0]         cr_row,
    output logic [SCORE_W-1:0]       cr_score,
    output logic [ID_W-1:0]          cr_id,
    output logic                     cr_exhausted,
    input  logic [ROW_W-1:0]         buf_row,
    output logic [ID_W-1:0]          buf_id,
    output logic                     buf_valid,
    output logic [ROWS*ID_W-1:0]     id_out,
    output logic [ROWS-1:0]          id_valid,
    output logic [ROW_W:0]           rows_filled
);
    localparam logic [ROW_W:0] FILL_MAX = (ROW_W + 1)'(ROWS);

    sb_state_e                   state_q;
    logic                        done_q;
    logic                        accept;
    logic                        new_row;
    logic [ROWS-1:0]             row_we;
    logic [ROWS-1:0]             row_written;
    logic [ROWS-1:0]             row_exhausted;
    logic [ROWS-1:0][1:0]        row_cmd;
    logic [ROWS-1:0][SCORE_W-1:0] row_score;
    logic [ROWS-1:0][ID_W-1:0]   row_id;

    assign wr.wr_ready = (state_q == IDLE) && !new_frame;
    assign wr.wr_done  = done_q && !new_frame;
    assign accept      = wr.wr_valid && wr.wr_ready;
    // Out-of-range rows decode to no row, so they are not counted but still acknowledged.
    assign new_row     = |(row_we & ~row_written);

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            rows_filled <= '0;
        end else if (new_frame) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            rows_filled <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= ACK;
                        done_q  <= 1'b1;
                        if (new_row && (rows_filled != FILL_MAX))
                            rows_filled <= rows_filled + (ROW_W + 1)'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        assign row_we[i]  = accept && (wr.wr_row == ROW_W'(i));
        assign row_cmd[i] = (ptr_row == ROW_W'(i)) ? ptr_cmd : PTR_NONE;

        oflow_sb_row #(
            .K       (K),
            .SCORE_W (SCORE_W),
            .ID_W    (ID_W),
            .PTR_W   (PTR_W)
        ) u_row (
            .clk       (clk),
            .reset_N   (reset_N),
            .clr       (new_frame),
            .we        (row_we[i]),
            .wr_scores (wr.wr_scores),
            .wr_ids    (wr.wr_ids),
            .ptr_cmd   (row_cmd[i]),
            .ptr_val   (ptr_val),
            .act_score (row_score[i]),
            .act_id    (row_id[i]),
            .act_valid (id_valid[i]),
            .exhausted (row_exhausted[i]),
            .written   (row_written[i])
        );

        assign id_out[i*ID_W +: ID_W] = row_id[i];
    end

    always_comb begin
        cr_score     = INVALID_SCORE[SCORE_W-1:0];
        cr_id        = '0;
        cr_exhausted = 1'b0;
        buf_id       = '0;
        buf_valid    = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            if (cr_row == ROW_W'(i)) begin
                cr_score     = row_score[i];
                cr_id        = row_id[i];
                cr_exhausted = row_exhausted[i];
            end
            if (buf_row == ROW_W'(i)) begin
                buf_id    = row_id[i];
                buf_valid = id_valid[i];
            end
        end
    end

endmodule
